// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its write-side arbiter.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_SIZE  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);
  // Walk from the far end so the candidate closest to rr_ptr is assigned last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int c;
      c = int'(rr_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        idx   = IDX_W'(c);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port; a grant is held until the
// owner's last word or MAX_BURST words so packets stay contiguous.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               xfer, rel;
  logic [IDX_W-1:0]   ptr_after;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign busy      = (state_q == GRANT);
  assign grant     = grant_q;
  assign xfer      = busy & req_valid[owner_q] & ~full;
  assign rel       = xfer & (req_last[owner_q] | (burst_cnt_q == CNT_W'(MAX_BURST - 1)));
  assign ptr_after = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // full gates ready as well as wr_en so a requester never sees a lost accept.
  assign req_ready = (busy & ~full) ? grant_q : '0;
  assign wr_en     = xfer;
  assign wr_data   = busy ? req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_d     = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          grant_d     = NUM_REQ'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (rel) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_after;
            grant_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4, DEPTH = 16;

  logic              wr_clk = 1'b0;
  logic              wr_rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0]   req_data;
  logic              full, wr_en, busy;
  logic [DW-1:0]     wr_data;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .full(full), .wr_en(wr_en),
    .wr_data(wr_data), .grant(grant), .busy(busy)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model: depth 16, registered full ----------------
  logic [DW-1:0] fq[$], wlog[$];
  logic full_m = 1'b0, tbl_full = 1'b0, use_tbl = 1'b1, rd_on = 1'b0;
  int   rd_pct = 100;
  logic cap_en = 1'b0;
  logic [DW-1:0] cap_d = '0;
  assign full = use_tbl ? tbl_full : full_m;

  always @(posedge wr_clk) begin
    if (cap_en) begin
      checks++;
      if (fq.size() >= DEPTH) begin
        errors++;
        $display("FAIL overflow: write of %0h into %0d entries", cap_d, fq.size());
      end
      fq.push_back(cap_d);
      wlog.push_back(cap_d);
    end
    if (rd_on && fq.size() > 0 && $urandom_range(99) < rd_pct) void'(fq.pop_front());
    full_m <= (fq.size() >= DEPTH);
  end

  // ---------------- reference model ----------------
  // owner -1 means nobody holds the port; ptr is where the next search starts.
  int m_owner = -1, m_ptr = 0, m_cnt = 0;
  int n_owner = -1, n_ptr = 0, n_cnt = 0;
  logic [N-1:0]  acc = '0;
  logic          p_hold = 1'b0, p_last = 1'b0;
  logic [DW-1:0] p_data = '0;

  always @(negedge wr_rst_n) begin
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    n_owner = -1; n_ptr = 0; n_cnt = 0;
    p_hold = 1'b0;
  end

  always @(negedge wr_clk) begin
    logic [N-1:0]  eg, er;
    logic          ew;
    logic [DW-1:0] ed;
    int            c;
    cap_en = wr_en;
    cap_d  = wr_data;
    acc    = req_valid & req_ready;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    ew = (m_owner >= 0) && req_valid[m_owner] && !full;
    er = (m_owner >= 0 && !full) ? eg : '0;
    ed = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_busy", 32'(busy), 32'(m_owner >= 0));
    chk("m_wr_en", 32'(wr_en), 32'(ew));
    chk("m_ready", 32'(req_ready), 32'(er));
    chk("m_wr_data", 32'(wr_data), 32'(ed));
    if (p_hold && m_owner >= 0 && req_valid[m_owner])
      assert (req_data[m_owner*DW +: DW] == p_data && req_last[m_owner] == p_last)
        else $error("requester %0d changed data/last while stalled", m_owner);
    p_hold = (m_owner >= 0) && req_valid[m_owner] && !req_ready[m_owner];
    if (m_owner >= 0) begin
      p_data = req_data[m_owner*DW +: DW];
      p_last = req_last[m_owner];
    end
    n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (req_valid[c]) begin
          n_owner = c;
          n_cnt   = 0;
          break;
        end
      end
    end else if (ew) begin
      n_cnt = m_cnt + 1;
      if (req_last[m_owner] || n_cnt == MB) begin
        n_owner = -1;
        n_ptr   = (m_owner + 1) % N;
      end
    end
  end

  always @(posedge wr_clk) begin
    if (wr_rst_n) begin
      m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
    end
  end

  // ---------------- queue-driven requesters ----------------
  logic [DW:0]  pq[N][$];
  logic         drv_on = 1'b0;
  logic [N-1:0] stall = '0;
  int           vpct = 100;

  always @(posedge wr_clk) begin
    logic [DW:0] w;
    #1;
    if (drv_on) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          w = pq[i][0];
          req_last[i] = w[DW];
          req_data[i*DW +: DW] = w[DW-1:0];
          req_valid[i] = (!stall[i] && $urandom_range(99) < vpct) ? 1'b1 : 1'b0;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic quiesce();
    @(negedge wr_clk);
    drv_on = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; stall = '0;
    for (int i = 0; i < N; i++) pq[i].delete();
    @(negedge wr_clk);
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    wr_rst_n = 1'b0;
    @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    fq.delete();
    wlog.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (wlog.size() < n && c < budget) begin
      @(negedge wr_clk);
      c++;
    end
    checks++;
    if (wlog.size() < n) begin
      errors++;
      $display("FAIL %s timeout: %0d words written, needed %0d", nm, wlog.size(), n);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]    v, l;
    logic [N*DW-1:0] d;
    logic            f;
    logic [N-1:0]    g;
    logic            b, we;
    logic [DW-1:0]   wd;
    logic [N-1:0]    rdy;
  } vec_t;

  vec_t         tv[12];
  logic [N-1:0] rr_exp[10];
  logic [DW-1:0] bexp[7], sexp[4], fexp[3];
  int           tot[N];

  initial begin
    req_valid = '0; req_last = '0; req_data = '0;
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);

    // req 2 packet A0..A2, then rr_ptr=3 makes req 3 beat req 0, then full stall
    tv[0]  = '{4'b0100, 4'b0000, 32'h00A0_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[1]  = '{4'b0100, 4'b0000, 32'h00A0_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'hA0, 4'b0100};
    tv[2]  = '{4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'hA1, 4'b0100};
    tv[3]  = '{4'b0100, 4'b0100, 32'h00A2_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0100};
    tv[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[5]  = '{4'b1001, 4'b1001, 32'hB000_00C0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[6]  = '{4'b1001, 4'b1001, 32'hB000_00C0, 1'b0, 4'b1000, 1'b1, 1'b1, 8'hB0, 4'b1000};
    tv[7]  = '{4'b0001, 4'b0000, 32'h0000_00C0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tv[8]  = '{4'b0001, 4'b0010, 32'h0000_00C0, 1'b1, 4'b0001, 1'b1, 1'b0, 8'hC0, 4'b0000};
    tv[9]  = '{4'b0001, 4'b0010, 32'h0000_00C0, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hC0, 4'b0001};
    tv[10] = '{4'b0001, 4'b0001, 32'h0000_00C1, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hC1, 4'b0001};
    tv[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};

    @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_valid = tv[k].v; req_last = tv[k].l; req_data = tv[k].d; tbl_full = tv[k].f;
      @(negedge wr_clk);
      chk($sformatf("tbl%0d_grant", k), 32'(grant), 32'(tv[k].g));
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tv[k].b));
      chk($sformatf("tbl%0d_wr_en", k), 32'(wr_en), 32'(tv[k].we));
      chk($sformatf("tbl%0d_wr_data", k), 32'(wr_data), 32'(tv[k].wd));
      chk($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tv[k].rdy));
      @(posedge wr_clk);
      #1;
    end

    // async reset mid-grant; rr_ptr was 1, so after reset req 0 must win over req 3
    req_valid = 4'b0100; req_last = 4'b0000; req_data = 32'h00D0_0000;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1 chk("pre_rst_grant", 32'(grant), 32'h4);
    #1 wr_rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_wr_en", 32'(wr_en), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'hB100_00C1;
    @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    @(negedge wr_clk);
    chk("arst_idle", 32'(grant), 32'h0);
    @(negedge wr_clk);
    chk("arst_ptr0", 32'(grant), 32'h1);
    quiesce();
    use_tbl = 1'b0;

    // round robin: everyone valid with last on every word
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h4030_2010;
    rr_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    for (int c = 0; c < 10; c++) begin
      @(negedge wr_clk);
      chk($sformatf("rr_grant%0d", c), 32'(grant), 32'(rr_exp[c]));
    end
    quiesce();

    // burst limit: req 1 six words, req 3 one word
    do_reset();
    for (int j = 0; j < 6; j++) pq[1].push_back({(j == 5), 8'(8'h10 + j)});
    pq[3].push_back({1'b1, 8'h30});
    vpct = 100;
    drv_on = 1'b1;
    wait_log(7, 80, "burst");
    bexp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h14, 8'h15};
    chk("burst_count", 32'(wlog.size()), 32'd7);
    for (int k = 0; k < 7 && k < wlog.size(); k++)
      chk($sformatf("burst_word%0d", k), 32'(wlog[k]), 32'(bexp[k]));
    quiesce();

    // full backpressure: 15 entries preloaded, reader off
    do_reset();
    rd_on = 1'b0;
    for (int j = 0; j < 15; j++) fq.push_back(8'hEE);
    @(posedge wr_clk);
    #1;
    pq[0].push_back({1'b0, 8'h50});
    pq[0].push_back({1'b0, 8'h51});
    pq[0].push_back({1'b1, 8'h52});
    drv_on = 1'b1;
    wait_log(1, 20, "full_first");
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("full_flag%0d", c), 32'(full), 32'h1);
      chk($sformatf("full_wr_en%0d", c), 32'(wr_en), 32'h0);
      chk($sformatf("full_ready%0d", c), 32'(req_ready), 32'h0);
      chk($sformatf("full_grant%0d", c), 32'(grant), 32'h1);
      @(negedge wr_clk);
    end
    rd_on = 1'b1; rd_pct = 100;
    wait_log(3, 40, "full_rest");
    fexp = '{8'h50, 8'h51, 8'h52};
    chk("full_count", 32'(wlog.size()), 32'd3);
    for (int k = 0; k < 3 && k < wlog.size(); k++)
      chk($sformatf("full_word%0d", k), 32'(wlog[k]), 32'(fexp[k]));
    quiesce();

    // owner stall: req 0 drops valid mid-packet while req 2 waits
    do_reset();
    pq[0].push_back({1'b0, 8'h60});
    pq[0].push_back({1'b0, 8'h61});
    pq[0].push_back({1'b1, 8'h62});
    pq[2].push_back({1'b1, 8'h70});
    drv_on = 1'b1;
    wait_log(1, 20, "stall_first");
    stall[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge wr_clk);
      chk($sformatf("stall_grant%0d", c), 32'(grant), 32'h1);
      chk($sformatf("stall_wr_en%0d", c), 32'(wr_en), 32'h0);
    end
    stall[0] = 1'b0;
    wait_log(4, 40, "stall_rest");
    sexp = '{8'h60, 8'h61, 8'h62, 8'h70};
    chk("stall_count", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++)
      chk($sformatf("stall_word%0d", k), 32'(wlog[k]), 32'(sexp[k]));
    quiesce();

    // random traffic: per-requester sequence numbers tagged in the data
    do_reset();
    rd_on = 1'b1; rd_pct = 50; vpct = 70;
    for (int i = 0; i < N; i++) begin
      tot[i] = 0;
      for (int p = 0; p < 8; p++) begin
        int len;
        len = int'($urandom_range(6, 1));
        for (int j = 0; j < len; j++) begin
          pq[i].push_back({(j == len - 1), 2'(i), 6'(tot[i])});
          tot[i]++;
        end
      end
    end
    drv_on = 1'b1;
    wait_log(tot[0] + tot[1] + tot[2] + tot[3], 4000, "random");
    for (int i = 0; i < N; i++) begin
      int seq, ok;
      seq = 0; ok = 1;
      for (int k = 0; k < wlog.size(); k++) begin
        if (wlog[k][7:6] == 2'(i)) begin
          if (wlog[k][5:0] != 6'(seq)) ok = 0;
          seq++;
        end
      end
      chk($sformatf("rnd_count%0d", i), 32'(seq), 32'(tot[i]));
      chk($sformatf("rnd_order%0d", i), 32'(ok), 32'd1);
    end
    quiesce();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
